// File: rtl/key_pkg.sv
// Shared types and widths for the key click decoder and the DDS mode inputs it drives.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT2 = 2'd1,
    GUARD = 2'd2
  } click_state_t;

  localparam int WAVE_W = 2;
  localparam int STEP_W = 4;

endpackage

// File: rtl/click_window_timer.sv
// Click window counter: cleared on state entry, counts while enabled, flags cnt==T_WIN.
module click_window_timer #(
  parameter int T_WIN = 14_999_999
) (
  input  logic sclk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(T_WIN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(T_WIN);

  logic [CNT_W-1:0] cnt;

  assign expired = (cnt == CNT_LAST);

  // Holds at T_WIN so the counter cannot wrap if the FSM ever lingers.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/key_click_decoder.sv
// Classifies debounced key pulse bursts as single or double clicks and steps the
// DDS waveform select / frequency step registers accordingly.
//
//   state | meaning
//   IDLE  | no burst in progress, waiting for a first press
//   WAIT2 | first press seen, window open for a second press
//   GUARD | double click issued, further presses ignored until window ends
module key_click_decoder
  import key_pkg::*;
#(
  parameter int T_WIN    = 14_999_999,
  parameter int WAVE_NUM = 4,
  parameter int STEP_MAX = 15
) (
  input  logic              sclk,
  input  logic              rst_n,
  input  logic              key_pulse,
  output logic              single_click,
  output logic              double_click,
  output logic [WAVE_W-1:0] wave_sel,
  output logic [STEP_W-1:0] freq_step,
  output logic              busy
);

  localparam logic [WAVE_W-1:0] WAVE_LAST = WAVE_W'(WAVE_NUM - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_MAX);

  click_state_t state, state_nx;
  logic         single_nx, double_nx;
  logic         timer_clear, timer_enable, expired;

  click_window_timer #(.T_WIN(T_WIN)) u_timer (
    .sclk    (sclk),
    .rst_n   (rst_n),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (expired)
  );

  assign timer_enable = (state != IDLE);
  assign busy         = (state != IDLE);

  // A press on the expiry edge of WAIT2 still counts as a double click.
  always_comb begin
    state_nx    = state;
    single_nx   = 1'b0;
    double_nx   = 1'b0;
    timer_clear = 1'b0;
    case (state)
      IDLE: begin
        timer_clear = 1'b1;
        if (key_pulse) state_nx = WAIT2;
      end
      WAIT2: begin
        if (key_pulse) begin
          double_nx   = 1'b1;
          state_nx    = GUARD;
          timer_clear = 1'b1;
        end else if (expired) begin
          single_nx   = 1'b1;
          state_nx    = IDLE;
          timer_clear = 1'b1;
        end
      end
      GUARD: begin
        if (expired) begin
          state_nx    = IDLE;
          timer_clear = 1'b1;
        end
      end
      default: begin
        state_nx    = IDLE;
        timer_clear = 1'b1;
      end
    endcase
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      single_click <= 1'b0;
      double_click <= 1'b0;
      wave_sel     <= '0;
      freq_step    <= '0;
    end else begin
      state        <= state_nx;
      single_click <= single_nx;
      double_click <= double_nx;
      if (single_nx) begin
        wave_sel <= (wave_sel == WAVE_LAST) ? '0 : wave_sel + 1'b1;
      end
      if (double_nx) begin
        freq_step <= (freq_step == STEP_LAST) ? '0 : freq_step + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_key_click_decoder.sv
// Directed bench for key_click_decoder with a 10-cycle click window (T_WIN=9).
module tb_key_click_decoder;

  logic       sclk;
  logic       rst_n;
  logic       key_pulse;
  logic       single_click;
  logic       double_click;
  logic [1:0] wave_sel;
  logic [3:0] freq_step;
  logic       busy;

  int checks = 0;
  int errors = 0;

  key_click_decoder #(
    .T_WIN    (9),
    .WAVE_NUM (4),
    .STEP_MAX (15)
  ) dut (
    .sclk         (sclk),
    .rst_n        (rst_n),
    .key_pulse    (key_pulse),
    .single_click (single_click),
    .double_click (double_click),
    .wave_sel     (wave_sel),
    .freq_step    (freq_step),
    .busy         (busy)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge sclk);
      #1;
    end
  endtask

  // Pulse key_pulse for exactly the next sampled edge.
  task automatic press();
    key_pulse = 1'b1;
    tick(1);
    key_pulse = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic s, input logic d,
                          input logic [1:0] w, input logic [3:0] f, input logic b);
    chk({tag, ".single"}, 32'(single_click), 32'(s));
    chk({tag, ".double"}, 32'(double_click), 32'(d));
    chk({tag, ".wave"},   32'(wave_sel),     32'(w));
    chk({tag, ".freq"},   32'(freq_step),    32'(f));
    chk({tag, ".busy"},   32'(busy),         32'(b));
  endtask

  initial begin
    key_pulse = 1'b0;
    rst_n     = 1'b0;
    #23;
    chk_outs("reset", 0, 0, 2'd0, 4'd0, 0);
    rst_n = 1'b1;
    tick(2);
    chk_outs("idle", 0, 0, 2'd0, 4'd0, 0);

    // Single click
    press();
    chk_outs("sc_e0", 0, 0, 2'd0, 4'd0, 1);
    tick(9);
    chk_outs("sc_e9", 0, 0, 2'd0, 4'd0, 1);
    tick(1);
    chk_outs("sc_e10", 1, 0, 2'd1, 4'd0, 0);
    tick(1);
    chk_outs("sc_e11", 0, 0, 2'd1, 4'd0, 0);

    // Double click, second press at E0+5
    press();
    tick(4);
    press();
    chk_outs("dc_e5", 0, 1, 2'd1, 4'd1, 1);
    tick(9);
    chk_outs("dc_e14", 0, 0, 2'd1, 4'd1, 1);
    tick(1);
    chk_outs("dc_e15", 0, 0, 2'd1, 4'd1, 0);

    // Tie: second press on the expiry edge E0+10
    press();
    tick(9);
    press();
    chk_outs("tie_e10", 0, 1, 2'd1, 4'd2, 1);
    tick(9);
    chk_outs("tie_e19", 0, 0, 2'd1, 4'd2, 1);
    tick(1);
    chk_outs("tie_e20", 0, 0, 2'd1, 4'd2, 0);

    // Second press one edge late at E0+11: single, then a fresh decode
    press();
    tick(9);
    tick(1);
    chk_outs("late_e10", 1, 0, 2'd2, 4'd2, 0);
    press();
    chk_outs("late_e11", 0, 0, 2'd2, 4'd2, 1);
    tick(9);
    chk_outs("late_n9", 0, 0, 2'd2, 4'd2, 1);
    tick(1);
    chk_outs("late_n10", 1, 0, 2'd3, 4'd2, 0);
    tick(1);

    // Guard and burst: presses at E0, E0+2, E0+4, E0+12
    press();
    tick(1);
    press();
    chk_outs("burst_e2", 0, 1, 2'd3, 4'd3, 1);
    tick(1);
    press();
    chk_outs("burst_e4", 0, 0, 2'd3, 4'd3, 1);
    tick(7);
    chk_outs("burst_e11", 0, 0, 2'd3, 4'd3, 1);
    press();
    chk_outs("burst_e12", 0, 0, 2'd3, 4'd3, 0);
    tick(1);
    chk_outs("burst_e13", 0, 0, 2'd3, 4'd3, 0);

    // Wrap: restart from reset values
    rst_n = 1'b0;
    #2;
    chk_outs("rst2", 0, 0, 2'd0, 4'd0, 0);
    rst_n = 1'b1;
    tick(1);
    for (int i = 0; i < 4; i++) begin
      press();
      tick(10);
      chk("wrap_single", 32'(single_click), 32'd1);
      chk("wrap_wave", 32'(wave_sel), 32'((i + 1) % 4));
      tick(1);
    end
    for (int i = 0; i < 16; i++) begin
      press();
      tick(1);
      press();
      chk("wrap_double", 32'(double_click), 32'd1);
      chk("wrap_freq", 32'(freq_step), 32'((i + 1) % 16));
      tick(10);
      chk("wrap_guard_done", 32'(busy), 32'd0);
    end

    // Reset in the middle of a window
    press();
    tick(1);
    press();
    tick(10);
    press();
    tick(10);
    chk_outs("pre_rst", 1, 0, 2'd1, 4'd1, 0);
    tick(1);
    press();
    tick(4);
    #2;
    rst_n = 1'b0;
    #1;
    chk_outs("rst_mid", 0, 0, 2'd0, 4'd0, 0);
    @(negedge sclk);
    rst_n = 1'b1;
    tick(1);
    for (int i = 0; i < 15; i++) begin
      chk("no_stale_single", 32'(single_click), 32'd0);
      chk("no_stale_busy", 32'(busy), 32'd0);
      tick(1);
    end
    press();
    chk_outs("post_rst_e0", 0, 0, 2'd0, 4'd0, 1);
    tick(10);
    chk_outs("post_rst_e10", 1, 0, 2'd1, 4'd0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
